pilots_extract_axi_stream: RTL and testbench
============================================

# pilots_extract_axi_stream

Receive-side subcarrier demultiplexer for the OFDM chain. It sits after the receiver FFT and consumes one 64-sample symbol in natural subcarrier order (index 0..63). Null subcarriers are dropped. The 48 data subcarriers go to a data stream and the 4 pilots go to a separate stream for channel/phase tracking. This block undoes the transmit pilot-insertion mapping (nulls at 0 and 27..37, pilots at 7/21/43/57).

## Interface
- `PILOT_SIGN`, default 4'b1000: bit k=1 means pilot k was transmitted negative (k=0..3 for indices 7,21,43,57).
- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `s_axis_tvalid` input 1: FFT sample valid.
- `s_axis_tready` output 1: sample accepted when both tvalid and tready are high.
- `s_axis_tdata` input 32: {Q[31:16], I[15:0]}, signed Q1.15.
- `s_axis_tlast` input 1: last sample of frame (index 63 of last symbol).
- `s_axis_symb_tlast` input 1: last sample of symbol (index 63).
- `m_data_tvalid`, `m_data_tready`, `m_data_tdata[31:0]`, `m_data_tlast`, `m_data_symb_tlast`: data subcarrier output, 48 beats/symbol.
- `m_pilot_tvalid`, `m_pilot_tready`, `m_pilot_tdata[31:0]`: pilot output, 4 beats/symbol.
- `m_pilot_tuser` output 2: pilot index k.
- `symb_err` output 1: one-cycle pulse on symbol misalignment.

## Operation
- `sc_cnt[5:0]` is the subcarrier index of the next accepted sample. It increments on each accepted beat and wraps from 63 to 0.
- Classification of `sc_cnt`:
  - NULL: 0 and 27..37.
  - PILOT: 7, 21, 43, 57, mapped to k = 0, 1, 2, 3.
  - DATA: all other indices (48 in total).
- NULL beats are accepted and discarded. They produce no output.
- DATA beats load the data output register with tdata unchanged.
  - `m_data_tlast` = `s_axis_tlast` of that beat.
  - `m_data_symb_tlast` = `s_axis_symb_tlast` of that beat.
  - Index 63 is DATA, so both flags always land on a data beat.
- PILOT beats load the pilot output register with `m_pilot_tuser` = k. Pilot data handling is set by `PILOT_DEROTATE_EN` (see Configuration).
- Resynchronisation:
  - `s_axis_symb_tlast` accepted with `sc_cnt` != 63: the beat is still routed by `sc_cnt`, `sc_cnt` is forced to 0, and `symb_err` pulses.
  - `sc_cnt` == 63 accepted without `s_axis_symb_tlast`: `symb_err` pulses and the counter wraps normally.
- Reset (asynchronous, any time, including mid-symbol): `sc_cnt`=0 and `s_axis_tready`=0. All outputs are 0: both tvalids, both tdatas, tlast, symb_tlast, tuser, `symb_err`. Any partial symbol is discarded.

## Timing
- Latency is 1 cycle from an accepted input beat to the corresponding output tvalid.
- Each output is a single register stage. A register holds its data stable while tvalid=1 and tready=0.
- `s_axis_tready` = (!m_data_tvalid | m_data_tready) & (!m_pilot_tvalid | m_pilot_tready). It is combinational from the output readies, with no combinational path from `s_axis_tvalid`.
- A stalled pilot output also stalls data input, and vice versa. This is accepted: pilot traffic is sparse.
- In the same cycle, an output register may drain (tready=1) and reload. Sustained throughput is 1 sample/cycle when both readies are high.
- A tvalid clears on the cycle its output handshakes, unless new data of that type is loaded.
- NULL beats leave both output registers untouched but still require `s_axis_tready`.
- `symb_err` is registered and asserts the cycle after the offending beat.

## Configuration
- `PILOT_DEROTATE_EN` defined:
  - For pilot k with `PILOT_SIGN[k]`=1, I and Q are each negated with saturation: -(-32768) gives 32767.
  - Pilots with `PILOT_SIGN[k]`=0 pass unchanged.
- `PILOT_DEROTATE_EN` undefined: pilots pass raw and `PILOT_SIGN` is unused.
- Latency is identical in both builds.

## Test plan
- **Ordering:** one symbol with tdata = {16'h0, index}, both readies high. Expect 48 data beats with I = 1..6, 8..20, 22..26, 38..42, 44..56, 58..63, and symb_tlast only on I=63. Expect pilot beats I = 7, 21, 43, 57 with tuser 0..3 (derotation build: pilot 3 I = -57). No output for nulls.
- **Saturation (`PILOT_DEROTATE_EN`):** pilot index 57 tdata = 32'h8000_8000. Expect `m_pilot_tdata` = 32'h7FFF_7FFF. Index 7 with 32'h8000_8000 passes unchanged.
- **Backpressure:** hold `m_pilot_tready`=0 while pilot 7 is pending. Expect `s_axis_tready`=0 and `m_pilot_tdata` stable until release, with no data loss across 3 consecutive symbols. Random tready on both outputs gives 144 data and 12 pilot beats in order.
- **Misalignment:** `s_axis_symb_tlast` on index 40. Expect `symb_err` pulse 1 cycle later, and the next sample treated as index 0 (dropped as null).
- **Frame end:** 2-symbol frame with tlast on the final sample. Expect `m_data_tlast`=1 only on the 96th data beat.
- **Reset:** `rst_n` pulsed low mid-symbol at index 30. Expect all outputs 0 immediately, and a following full symbol output correctly from index 0.

Source files
------------

// File: rtl/pilots_extract_axi_stream.sv
// -----------------------------------------------------------------------------
// pilots_extract_axi_stream
//
// Receive-side subcarrier demultiplexer. Consumes 64-sample OFDM symbols in
// natural subcarrier order straight from the FFT, drops the null carriers
// (0, 27..37), forwards the 48 data carriers on m_data_* and the 4 pilots
// (7, 21, 43, 57 -> k = 0..3) on m_pilot_*.
//
// Optional feature macro: PILOT_DEROTATE_EN
//   defined   : pilot k with PILOT_SIGN[k]=1 has I and Q negated with
//               saturation (-(-32768) -> 32767).
//   undefined : pilots pass raw; PILOT_SIGN has no effect.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_axis_tvalid/tready       input handshake
//   s_axis_tdata[31:0]         {Q[31:16], I[15:0]} signed Q1.15
//   s_axis_tlast               last sample of frame
//   s_axis_symb_tlast          last sample of symbol
//   m_data_*                   data carrier stream (tdata, tlast, symb_tlast)
//   m_pilot_*                  pilot stream, tuser = pilot index k
//   symb_err                   one-cycle pulse on symbol misalignment
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high. Output tvalid/tdata/flags stay constant while tvalid=1 and
// tready=0. s_axis_tready depends only on the output register state and the
// output readies, never on s_axis_tvalid.
// -----------------------------------------------------------------------------
module pilots_extract_axi_stream #(
  parameter logic [3:0] PILOT_SIGN = 4'b1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  input  logic        s_axis_symb_tlast,
  output logic        m_data_tvalid,
  input  logic        m_data_tready,
  output logic [31:0] m_data_tdata,
  output logic        m_data_tlast,
  output logic        m_data_symb_tlast,
  output logic        m_pilot_tvalid,
  input  logic        m_pilot_tready,
  output logic [31:0] m_pilot_tdata,
  output logic [1:0]  m_pilot_tuser,
  output logic        symb_err
);

  logic [5:0]  sc_cnt_q, sc_cnt_d;
  logic        data_valid_q, data_valid_d;
  logic [31:0] data_tdata_q, data_tdata_d;
  logic        data_tlast_q, data_tlast_d;
  logic        data_slast_q, data_slast_d;
  logic        pilot_valid_q, pilot_valid_d;
  logic [31:0] pilot_tdata_q, pilot_tdata_d;
  logic [1:0]  pilot_k_q, pilot_k_d;
  logic        symb_err_q, symb_err_d;

  logic        accept;
  logic        is_null;
  logic        is_pilot;
  logic        is_data;
  logic [1:0]  pilot_k;
  logic [31:0] pilot_data;

  // Gated with rst_n so the input side is closed while reset is held.
  assign s_axis_tready = rst_n & (!data_valid_q | m_data_tready)
                               & (!pilot_valid_q | m_pilot_tready);
  assign accept = s_axis_tvalid & s_axis_tready;

  // Subcarrier classification of the index the current beat lands on.
  always_comb begin
    is_null  = 1'b0;
    is_pilot = 1'b0;
    pilot_k  = 2'd0;
    if (sc_cnt_q == 6'd0 || (sc_cnt_q >= 6'd27 && sc_cnt_q <= 6'd37)) begin
      is_null = 1'b1;
    end
    case (sc_cnt_q)
      6'd7:    begin is_pilot = 1'b1; pilot_k = 2'd0; end
      6'd21:   begin is_pilot = 1'b1; pilot_k = 2'd1; end
      6'd43:   begin is_pilot = 1'b1; pilot_k = 2'd2; end
      6'd57:   begin is_pilot = 1'b1; pilot_k = 2'd3; end
      default: ;
    endcase
  end
  assign is_data = !is_null && !is_pilot;

`ifdef PILOT_DEROTATE_EN
  // Two's-complement negate, clamping the single unrepresentable case.
  function automatic logic [15:0] neg_sat(input logic [15:0] x);
    if (x == 16'h8000) return 16'h7FFF;
    return ~x + 16'd1;
  endfunction

  always_comb begin
    pilot_data = s_axis_tdata;
    if (PILOT_SIGN[pilot_k]) begin
      pilot_data = {neg_sat(s_axis_tdata[31:16]), neg_sat(s_axis_tdata[15:0])};
    end
  end
`else
  logic unused_pilot_sign;
  assign unused_pilot_sign = ^PILOT_SIGN;
  assign pilot_data = s_axis_tdata;
`endif

  always_comb begin
    // An output register drains on its handshake and may reload in the
    // same cycle.
    data_valid_d  = data_valid_q & !m_data_tready;
    data_tdata_d  = data_tdata_q;
    data_tlast_d  = data_tlast_q;
    data_slast_d  = data_slast_q;
    pilot_valid_d = pilot_valid_q & !m_pilot_tready;
    pilot_tdata_d = pilot_tdata_q;
    pilot_k_d     = pilot_k_q;
    sc_cnt_d      = sc_cnt_q;
    symb_err_d    = 1'b0;

    if (accept) begin
      if (is_data) begin
        data_valid_d = 1'b1;
        data_tdata_d = s_axis_tdata;
        data_tlast_d = s_axis_tlast;
        data_slast_d = s_axis_symb_tlast;
      end
      if (is_pilot) begin
        pilot_valid_d = 1'b1;
        pilot_tdata_d = pilot_data;
        pilot_k_d     = pilot_k;
      end
      // symb_tlast must coincide with index 63; any disagreement is an error.
      symb_err_d = s_axis_symb_tlast ^ (sc_cnt_q == 6'd63);
      // symb_tlast always realigns the counter to the start of a symbol.
      sc_cnt_d   = s_axis_symb_tlast ? 6'd0 : sc_cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_cnt_q      <= 6'd0;
      data_valid_q  <= 1'b0;
      data_tdata_q  <= 32'd0;
      data_tlast_q  <= 1'b0;
      data_slast_q  <= 1'b0;
      pilot_valid_q <= 1'b0;
      pilot_tdata_q <= 32'd0;
      pilot_k_q     <= 2'd0;
      symb_err_q    <= 1'b0;
    end else begin
      sc_cnt_q      <= sc_cnt_d;
      data_valid_q  <= data_valid_d;
      data_tdata_q  <= data_tdata_d;
      data_tlast_q  <= data_tlast_d;
      data_slast_q  <= data_slast_d;
      pilot_valid_q <= pilot_valid_d;
      pilot_tdata_q <= pilot_tdata_d;
      pilot_k_q     <= pilot_k_d;
      symb_err_q    <= symb_err_d;
    end
  end

  assign m_data_tvalid     = data_valid_q;
  assign m_data_tdata      = data_tdata_q;
  assign m_data_tlast      = data_tlast_q;
  assign m_data_symb_tlast = data_slast_q;
  assign m_pilot_tvalid    = pilot_valid_q;
  assign m_pilot_tdata     = pilot_tdata_q;
  assign m_pilot_tuser     = pilot_k_q;
  assign symb_err          = symb_err_q;

endmodule

// File: tb/tb_pilots_extract_axi_stream.sv
// -----------------------------------------------------------------------------
// Bench for pilots_extract_axi_stream. Inputs and readies change 1 time unit
// after the rising edge; everything is observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_pilots_extract_axi_stream;

  localparam logic [3:0] PSIGN = 4'b1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_symb_tlast = 1'b0;
  logic        m_data_tvalid;
  logic        m_data_tready = 1'b1;
  logic [31:0] m_data_tdata;
  logic        m_data_tlast;
  logic        m_data_symb_tlast;
  logic        m_pilot_tvalid;
  logic        m_pilot_tready = 1'b1;
  logic [31:0] m_pilot_tdata;
  logic [1:0]  m_pilot_tuser;
  logic        symb_err;

  pilots_extract_axi_stream #(.PILOT_SIGN(PSIGN)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_symb_tlast(s_axis_symb_tlast),
    .m_data_tvalid(m_data_tvalid), .m_data_tready(m_data_tready),
    .m_data_tdata(m_data_tdata), .m_data_tlast(m_data_tlast),
    .m_data_symb_tlast(m_data_symb_tlast),
    .m_pilot_tvalid(m_pilot_tvalid), .m_pilot_tready(m_pilot_tready),
    .m_pilot_tdata(m_pilot_tdata), .m_pilot_tuser(m_pilot_tuser),
    .symb_err(symb_err)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ready pattern: 0 both high, 1 random, 2 data high / pilot low
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: begin
        m_data_tready  = 1'($urandom_range(0, 1));
        m_pilot_tready = 1'($urandom_range(0, 1));
      end
      2: begin m_data_tready = 1'b1; m_pilot_tready = 1'b0; end
      default: begin m_data_tready = 1'b1; m_pilot_tready = 1'b1; end
    endcase
  end

  // ---------------- reference model (subcarrier map) ----------------
  // returns -1 null, 0..3 pilot k, 4 data
  function automatic int sc_kind(input int idx);
    int pil[4] = '{7, 21, 43, 57};
    if (idx == 0 || (idx >= 27 && idx <= 37)) return -1;
    for (int k = 0; k < 4; k++) if (pil[k] == idx) return k;
    return 4;
  endfunction

  function automatic logic [15:0] neg_model(input logic [15:0] x);
    int v;
    v = -int'($signed(x));
    if (v > 32767) v = 32767;
    return v[15:0];
  endfunction

  function automatic logic [31:0] pilot_model(input int k, input logic [31:0] d);
`ifdef PILOT_DEROTATE_EN
    if (PSIGN[k]) return {neg_model(d[31:16]), neg_model(d[15:0])};
`endif
    return d;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [33:0] exp_data_q[$];    // {tlast, symb_tlast, tdata}
  logic [33:0] exp_pilot_q[$];   // {k, tdata}
  logic [33:0] got_data_q[$];
  logic [33:0] got_pilot_q[$];
  int          model_idx = 0;
  logic        exp_err = 1'b0;
  logic        exp_dv_now = 1'b0, exp_pv_now = 1'b0;
  logic        hold_d = 1'b0, hold_p = 1'b0;
  logic [33:0] hold_d_val, hold_p_val;
  int          data_hs = 0, pilot_hs = 0;
  logic [33:0] e;
  int          kind;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs",
            {s_axis_tready, m_data_tvalid, m_data_tdata, m_data_tlast, m_data_symb_tlast,
             m_pilot_tvalid, m_pilot_tuser, symb_err}, 64'd0);
      check("reset_pilot_tdata", {32'd0, m_pilot_tdata}, 64'd0);
      exp_data_q.delete();
      exp_pilot_q.delete();
      model_idx = 0;
      exp_err = 1'b0;
      exp_dv_now = 1'b0; exp_pv_now = 1'b0;
      hold_d = 1'b0; hold_p = 1'b0;
    end else begin
      check("symb_err", symb_err, exp_err);
      check("s_tready", s_axis_tready,
            (!m_data_tvalid | m_data_tready) & (!m_pilot_tvalid | m_pilot_tready));
      if (exp_dv_now) check("data_latency", m_data_tvalid, 1'b1);
      if (exp_pv_now) check("pilot_latency", m_pilot_tvalid, 1'b1);
      if (hold_d) check("data_hold", {m_data_tvalid, m_data_tlast, m_data_symb_tlast, m_data_tdata},
                        {1'b1, hold_d_val});
      if (hold_p) check("pilot_hold", {m_pilot_tvalid, m_pilot_tuser, m_pilot_tdata},
                        {1'b1, hold_p_val});
      hold_d = m_data_tvalid & !m_data_tready;
      hold_d_val = {m_data_tlast, m_data_symb_tlast, m_data_tdata};
      hold_p = m_pilot_tvalid & !m_pilot_tready;
      hold_p_val = {m_pilot_tuser, m_pilot_tdata};

      if (m_data_tvalid && m_data_tready) begin
        data_hs++;
        got_data_q.push_back({m_data_tlast, m_data_symb_tlast, m_data_tdata});
        if (exp_data_q.size() == 0) check("data_unexpected", 1, 0);
        else begin
          e = exp_data_q.pop_front();
          check("data_beat", {m_data_tlast, m_data_symb_tlast, m_data_tdata}, e);
        end
      end
      if (m_pilot_tvalid && m_pilot_tready) begin
        pilot_hs++;
        got_pilot_q.push_back({m_pilot_tuser, m_pilot_tdata});
        if (exp_pilot_q.size() == 0) check("pilot_unexpected", 1, 0);
        else begin
          e = exp_pilot_q.pop_front();
          check("pilot_beat", {m_pilot_tuser, m_pilot_tdata}, e);
        end
      end

      exp_err = 1'b0;
      exp_dv_now = 1'b0; exp_pv_now = 1'b0;
      if (s_axis_tvalid && s_axis_tready) begin
        kind = sc_kind(model_idx);
        if (kind == 4) begin
          exp_data_q.push_back({s_axis_tlast, s_axis_symb_tlast, s_axis_tdata});
          exp_dv_now = 1'b1;
        end else if (kind >= 0) begin
          exp_pilot_q.push_back({kind[1:0], pilot_model(kind, s_axis_tdata)});
          exp_pv_now = 1'b1;
        end
        exp_err = s_axis_symb_tlast != (model_idx == 63);
        model_idx = s_axis_symb_tlast ? 0 : (model_idx + 1) % 64;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [31:0] d, input logic fl, input logic sl);
    int n;
    logic acc;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = d;
    s_axis_tlast = fl;
    s_axis_symb_tlast = sl;
    n = 0;
    do begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 1000);
    if (!acc) check("tready_timeout", acc, 1'b1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_symb_tlast = 1'b0;
  endtask

  // mode 0: tdata = index, 1: random, 2: random with 0x80008000 on 7 and 57
  task automatic send_symbol(input int mode, input logic frame_last,
                             input int first, input int bad_at, input logic no_slast);
    logic [31:0] d;
    for (int i = first; i < 64; i++) begin
      d = $urandom;
      if (mode == 0) d = {16'h0, 16'(i)};
      if (mode == 2 && (i == 7 || i == 57)) d = 32'h8000_8000;
      if (i == bad_at) begin
        send_beat(d, 1'b0, 1'b1);
        return;
      end
      send_beat(d, frame_last && i == 63, i == 63 && !no_slast);
    end
  endtask

  task automatic drain();
    int n;
    rdy_mode = 0;
    n = 0;
    while ((exp_data_q.size() != 0 || exp_pilot_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    check("drain", exp_data_q.size() + exp_pilot_q.size(), 0);
  endtask

  task automatic clear_got();
    got_data_q.delete();
    got_pilot_q.delete();
    data_hs = 0;
    pilot_hs = 0;
  endtask

  // ---------------- test sequence ----------------
  int          tl_cnt, tl_pos;
  logic [31:0] held;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_tready", s_axis_tready, 1'b1);
    @(posedge clk); #1;

    // Ordering
    clear_got();
    send_symbol(0, 1'b0, 0, -1, 1'b0);
    drain();
    check("ord_data_count", got_data_q.size(), 48);
    check("ord_data_first", got_data_q[0], {2'b00, 32'd1});
    check("ord_data_7th", got_data_q[6], {2'b00, 32'd8});
    check("ord_data_last", got_data_q[47], {2'b01, 32'd63});
    check("ord_pilot_count", got_pilot_q.size(), 4);
    check("ord_pilot_k1", got_pilot_q[1], {2'd1, 32'd21});
`ifdef PILOT_DEROTATE_EN
    check("ord_pilot_k3", got_pilot_q[3], {2'd3, 32'h0000_FFC7});
`else
    check("ord_pilot_k3", got_pilot_q[3], {2'd3, 32'd57});
`endif

    // Saturation
    clear_got();
    send_symbol(2, 1'b0, 0, -1, 1'b0);
    drain();
    check("sat_pilot_k0", got_pilot_q[0], {2'd0, 32'h8000_8000});
`ifdef PILOT_DEROTATE_EN
    check("sat_pilot_k3", got_pilot_q[3], {2'd3, 32'h7FFF_7FFF});
`else
    check("sat_pilot_k3", got_pilot_q[3], {2'd3, 32'h8000_8000});
`endif

    // Backpressure: pilot stalled, then random readies
    clear_got();
    rdy_mode = 2;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send_beat($urandom, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_stall_tready", {m_pilot_tvalid, s_axis_tready}, 2'b10);
    held = m_pilot_tdata;
    repeat (3) @(negedge clk);
    check("bp_stall_hold", {m_pilot_tvalid, s_axis_tready, m_pilot_tdata}, {2'b10, held});
    @(posedge clk); #1;
    rdy_mode = 1;
    send_symbol(1, 1'b0, 8, -1, 1'b0);
    send_symbol(1, 1'b0, 0, -1, 1'b0);
    send_symbol(1, 1'b0, 0, -1, 1'b0);
    drain();
    check("bp_data_count", data_hs, 144);
    check("bp_pilot_count", pilot_hs, 12);

    // Misalignment: early symb_tlast, then missing symb_tlast
    send_symbol(1, 1'b0, 0, 40, 1'b0);
    check("mis_early_err", symb_err, 1'b1);
    send_symbol(1, 1'b0, 0, -1, 1'b0);
    send_symbol(1, 1'b0, 0, -1, 1'b1);
    check("mis_missing_err", symb_err, 1'b1);
    send_symbol(1, 1'b0, 0, -1, 1'b0);
    drain();

    // Frame end
    clear_got();
    send_symbol(1, 1'b0, 0, -1, 1'b0);
    send_symbol(1, 1'b1, 0, -1, 1'b0);
    drain();
    tl_cnt = 0;
    tl_pos = -1;
    foreach (got_data_q[i]) if (got_data_q[i][33]) begin tl_cnt++; tl_pos = i + 1; end
    check("frame_data_count", got_data_q.size(), 96);
    check("frame_tlast_count", tl_cnt, 1);
    check("frame_tlast_pos", tl_pos, 96);

    // Reset mid-symbol at index 30
    rdy_mode = 1;
    send_symbol(1, 1'b0, 0, 30, 1'b0);  // stops after index 29? no: sends 0..29 then bad at 30
    rdy_mode = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = $urandom;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outs",
          {s_axis_tready, m_data_tvalid, m_data_tlast, m_data_symb_tlast,
           m_pilot_tvalid, m_pilot_tuser, symb_err}, 64'd0);
    check("async_reset_tdata", {m_data_tdata, m_pilot_tdata}, 64'd0);
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_got();
    send_symbol(0, 1'b0, 0, -1, 1'b0);
    drain();
    check("rst_data_count", got_data_q.size(), 48);
    check("rst_data_first", got_data_q[0], {2'b00, 32'd1});
    check("rst_pilot_first", got_pilot_q[0], {2'd0, 32'd7});

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
